muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised RV32M multiply/divide unit beside the integer execution stage.
- Accepts one M-extension operation at a time: pipelined multiply, or iterative radix-2 restoring divide.
- Returns the result with a one-cycle done pulse.
- Execution stage holds the instruction using busy_o; writeback consumes rd_o/rd_data_o on done_o.

Parameters:
- XLEN, 32, operand/result width (≥8, even)
- MUL_CYCLES, 2, multiply latency in cycles from accept to done_o (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_v_i  in  1  request valid
- funct3_i  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data_i  in  XLEN  operand a (dividend)
- rs2_data_i  in  XLEN  operand b (divisor)
- rd_i  in  5  destination register
- flush_i  in  1  abort in-flight op
- busy_o  out  1  op in flight, cannot accept
- done_o  out  1  result valid, one-cycle pulse
- rd_o  out  5  destination of completed op
- rd_data_o  out  XLEN  result

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset: state IDLE; busy_o=0, done_o=0, rd_o=0, rd_data_o=0. Reset mid-operation discards the op with no done_o.
- FSM states: IDLE, MUL, DIV, DONE. busy_o=1 in MUL and DIV only.
- Accept: req_v_i & !busy_o & !flush_i in IDLE or DONE. Back-to-back issue is allowed in the DONE cycle.
- On accept, capture funct3, rd, both operands, and operand signs. Next state is MUL (funct3<4) or DIV.
- MUL:
  - Full 2·XLEN product; a signed for MUL/MULH/MULHSU, b signed for MUL/MULH only.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Accepted at cycle T → done_o at cycle T+MUL_CYCLES (DONE state).
  - MUL_CYCLES=1: MUL state is skipped; DONE is entered directly.
- DIV:
  - Work on magnitudes: |a| and |b| for DIV/REM, raw values for DIVU/REMU.
  - Iteration counter runs 0..XLEN-1, one quotient bit per cycle, remainder register XLEN+1 bits.
  - After the last iteration, negate the quotient if the signs differ (signed ops). Negate the remainder if a<0 (signed ops).
  - Accepted at T → done_o at T+XLEN+1.
- Special cases, detected at accept, go directly to DONE with done_o at T+1:
  - Divide by zero: quotient all-ones, remainder = a.
  - Signed overflow (a = −2^(XLEN−1), b = −1): quotient = a, remainder = 0.
- DONE:
  - Lasts one cycle; done_o=1 with rd_o and rd_data_o valid.
  - Next state is IDLE, or MUL/DIV if a new op is accepted that cycle.
- rd_o and rd_data_o are registered and hold their last values when done_o=0.
- rd_i=0 is computed and reported normally; write suppression is downstream.
- flush_i:
  - Any state → IDLE next cycle, no done_o for the aborted op.
  - flush_i in the DONE cycle does not retract that done_o, but blocks any accept in that cycle.
  - flush_i together with req_v_i: the request is dropped.
- req_v_i while busy_o=1 is ignored. The upstream stage must hold the request until accepted.
- Operand inputs are don't-care after accept.

Test Plan:
- Multiply (XLEN=32, MUL_CYCLES=2):
  - MUL 7×0xFFFFFFFD accepted at T → done_o at T+2 only, rd_data_o=0xFFFFFFEB, busy_o=1 at T+1.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide:
  - DIV −7/2 (0xFFFFFFF9, 2) at T → done_o at T+33, 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIVU 0x1234/0 → done_o at T+1, 0xFFFFFFFF; REM 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM → 0.
- Flush and reset:
  - DIV accepted at T, flush_i at T+10 → busy_o=0 at T+11, no done_o.
  - New MUL 3×4 accepted at T+11 → done_o at T+13, 12.
  - reset asserted at T+5 of a DIV → all outputs 0 next cycle, no done_o.
- Back-to-back, with rd tracking:
  - MUL rd=5 done at T+2 while req_v_i=1 with DIV rd=6 → DIV accepted at T+2.
  - done_o for DIV at T+35 with rd_o=6.
  - req_v_i pulses during busy are ignored; exactly two done_o pulses total.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: multiply with a fixed short latency, radix-2
// restoring divide with one quotient bit per cycle, one-cycle done pulse.
module muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_v_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rd_data_o
);

    localparam int unsigned CNT_W    = $clog2(XLEN);
    localparam int unsigned MUL_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Captured operation context
    logic [4:0]      rd_q;
    logic            rem_sel_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] mul_q;
    logic [XLEN-1:0] div_q;
    logic [XLEN:0]   div_rem;
    logic [XLEN-1:0] div_den;
    logic            neg_q;
    logic            neg_r;

    // Decoded request operands
    logic              a_signed_c;
    logic              b_signed_c;
    logic [2*XLEN-1:0] a_ext_c;
    logic [2*XLEN-1:0] b_ext_c;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   mul_res_c;
    logic              div_signed_c;
    logic              a_neg_c;
    logic              b_neg_c;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;
    logic              div_zero_c;
    logic              div_ovf_c;
    logic [XLEN-1:0]   special_res_c;

    // Divider step
    logic [XLEN+1:0] shifted_c;
    logic            q_bit_c;
    logic [XLEN:0]   trial_c;
    logic [XLEN:0]   rem_next_c;
    logic [XLEN-1:0] q_next_c;
    logic [XLEN-1:0] quot_fin_c;
    logic [XLEN-1:0] rem_fin_c;
    logic [XLEN-1:0] div_res_c;

    // FSM decisions
    logic            accept_c;
    logic            load_c;
    logic [XLEN-1:0] result_d_c;
    logic [4:0]      rd_d_c;

    // Request decode: full product from sign-extended operands, divide magnitudes and special cases
    always_comb begin
        a_signed_c    = (funct3_i[1:0] != 2'b11);
        b_signed_c    = ~funct3_i[1];
        a_ext_c       = {{XLEN{a_signed_c & rs1_data_i[XLEN-1]}}, rs1_data_i};
        b_ext_c       = {{XLEN{b_signed_c & rs2_data_i[XLEN-1]}}, rs2_data_i};
        prod_c        = a_ext_c * b_ext_c;
        mul_res_c     = (funct3_i[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
        div_signed_c  = ~funct3_i[0];
        a_neg_c       = div_signed_c & rs1_data_i[XLEN-1];
        b_neg_c       = div_signed_c & rs2_data_i[XLEN-1];
        a_mag_c       = a_neg_c ? -rs1_data_i : rs1_data_i;
        b_mag_c       = b_neg_c ? -rs2_data_i : rs2_data_i;
        div_zero_c    = (rs2_data_i == '0);
        div_ovf_c     = div_signed_c & (rs1_data_i == INT_MIN) & (rs2_data_i == '1);
        special_res_c = '0;
        if (div_zero_c) begin
            special_res_c = funct3_i[1] ? rs1_data_i : '1;
        end else begin
            special_res_c = funct3_i[1] ? '0 : rs1_data_i;
        end
    end

    // One restoring-divide iteration plus final sign fix-up
    always_comb begin
        shifted_c  = {div_rem, div_q[XLEN-1]};
        q_bit_c    = (shifted_c >= {2'b00, div_den});
        trial_c    = shifted_c[XLEN:0] - {1'b0, div_den};
        rem_next_c = q_bit_c ? trial_c : shifted_c[XLEN:0];
        q_next_c   = {div_q[XLEN-2:0], q_bit_c};
        quot_fin_c = neg_q ? -q_next_c : q_next_c;
        rem_fin_c  = neg_r ? -rem_next_c[XLEN-1:0] : rem_next_c[XLEN-1:0];
        div_res_c  = rem_sel_q ? rem_fin_c : quot_fin_c;
    end

    // Next-state and result-load decisions
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        load_c     = 1'b0;
        result_d_c = '0;
        rd_d_c     = rd_q;
        if (flush_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    next_state = IDLE;
                    if (req_v_i) begin
                        accept_c = 1'b1;
                        if (!funct3_i[2]) begin
                            if (MUL_CYCLES == 1) begin
                                next_state = DONE;
                                load_c     = 1'b1;
                                result_d_c = mul_res_c;
                                rd_d_c     = rd_i;
                            end else begin
                                next_state = MUL;
                            end
                        end else if (div_zero_c || div_ovf_c) begin
                            next_state = DONE;
                            load_c     = 1'b1;
                            result_d_c = special_res_c;
                            rd_d_c     = rd_i;
                        end else begin
                            next_state = DIV;
                        end
                    end
                end
                MUL: begin
                    if (cnt == CNT_W'(MUL_LAST)) begin
                        next_state = DONE;
                        load_c     = 1'b1;
                        result_d_c = mul_q;
                    end
                end
                DIV: begin
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        next_state = DONE;
                        load_c     = 1'b1;
                        result_d_c = div_res_c;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and operation datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rd_o      <= '0;
            rd_data_o <= '0;
            rd_q      <= '0;
            rem_sel_q <= 1'b0;
            cnt       <= '0;
            mul_q     <= '0;
            div_q     <= '0;
            div_rem   <= '0;
            div_den   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            busy_o <= (next_state == MUL) || (next_state == DIV);
            done_o <= (next_state == DONE);
            if (load_c) begin
                rd_o      <= rd_d_c;
                rd_data_o <= result_d_c;
            end
            if (accept_c) begin
                rd_q      <= rd_i;
                rem_sel_q <= funct3_i[1];
                cnt       <= '0;
                mul_q     <= mul_res_c;
                div_q     <= a_mag_c;
                div_rem   <= '0;
                div_den   <= b_mag_c;
                neg_q     <= a_neg_c ^ b_neg_c;
                neg_r     <= a_neg_c;
            end else if ((state == MUL) || (state == DIV)) begin
                cnt <= cnt + CNT_W'(1);
                if (state == DIV) begin
                    div_q   <= q_next_c;
                    div_rem <= rem_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed steps, expected results queued at accept
// and compared by a monitor when done_o fires.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  rd_o;
    logic [31:0] rd_data_o;

    muldiv_unit #(.XLEN(32), .MUL_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_v_i    (req_v_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_o       (rd_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;
    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every done_o must match the oldest pending expectation
    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            checks++;
            assert (sbq.size() > 0) else begin
                errors++;
                $error("FAIL spurious_done: observed done_o rd_o=%0d at cycle %0d, expected no pending op", rd_o, cyc);
            end
            if (sbq.size() > 0) begin
                e_mon = sbq.pop_front();
                check("done_rd", 32'(rd_o), 32'(e_mon.rd));
                check("done_data", rd_data_o, e_mon.data);
                check("done_cycle", 32'(cyc), 32'(e_mon.cyc));
            end
        end
    end

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = sa * sbv;  return p[31:0];  end
            3'd1: begin p = sa * sbv;  return p[63:32]; end
            3'd2: begin p = sa * ub;   return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sbv;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sbv;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 3'd4) return 2;
        if (b == 0) return 1;
        if (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_v_i    = 1'b1;
        funct3_i   = f;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_i       = rd;
    endtask

    task automatic release_req();
        req_v_i    = 1'b0;
        funct3_i   = 3'($urandom);
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        rd_i       = 5'($urandom);
    endtask

    // Issue one op from an idle unit and wait through its done cycle
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        lat = ref_lat(f, a, b);
        drive(f, a, b, rd);
        sbq.push_back('{rd, exp, cyc + lat});
        step();
        release_req();
        check("busy_after_accept", 32'(busy_o), 32'(lat > 1));
        repeat (lat - 1) step();
        @(negedge clk);
        #1;
        check("sb_drained", 32'(sbq.size()), 32'd0);
        step();
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    int dn0;

    initial begin
        reset = 1'b1; req_v_i = 1'b0; funct3_i = '0; rs1_data_i = '0;
        rs2_data_i = '0; rd_i = '0; flush_i = 1'b0;
        step();
        step();
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_rd", 32'(rd_o), 32'd0);
        check("reset_data", rd_data_o, 32'd0);
        reset = 1'b0;
        step();

        // Multiply
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
        run_op(3'd0, 32'd3, 32'd5, 5'd0, 32'd15);

        // Divide
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd10, 32'd2);

        // Special cases
        run_op(3'd5, 32'h1234, 32'd0, 5'd11, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h1234, 32'd0, 5'd12, 32'h1234);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0);

        // Flush mid-divide, then a fresh multiply
        drive(3'd4, 32'd1000, 32'd3, 5'd20);
        step();
        release_req();
        repeat (9) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_done", 32'(done_o), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd21, 32'd12);

        // Flush together with a request drops the request
        drive(3'd0, 32'd2, 32'd2, 5'd25);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        release_req();
        check("flush_req_busy", 32'(busy_o), 32'd0);
        repeat (3) step();

        // Flush in the done cycle keeps that done and blocks the new request
        drive(3'd0, 32'd6, 32'd7, 5'd22);
        sbq.push_back('{5'd22, 32'd42, cyc + 2});
        step();
        release_req();
        step();
        drive(3'd4, 32'd50, 32'd5, 5'd26);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        release_req();
        check("flush_done_busy", 32'(busy_o), 32'd0);
        check("flush_done_drained", 32'(sbq.size()), 32'd0);
        repeat (3) step();

        // Reset in the middle of a divide
        drive(3'd5, 32'hDEAD_BEEF, 32'd17, 5'd23);
        step();
        release_req();
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_done", 32'(done_o), 32'd0);
        check("rst_mid_rd", 32'(rd_o), 32'd0);
        check("rst_mid_data", rd_data_o, 32'd0);
        repeat (36) step();
        check("rst_mid_idle", 32'(busy_o), 32'd0);

        // Back-to-back issue in the done cycle, pulses while busy ignored
        dn0 = done_cnt;
        drive(3'd0, 32'd5, 32'd6, 5'd5);
        sbq.push_back('{5'd5, 32'd30, cyc + 2});
        step();
        check("b2b_busy_mul", 32'(busy_o), 32'd1);
        drive(3'd5, 32'd100, 32'd7, 5'd6);
        step();
        sbq.push_back('{5'd6, 32'd14, cyc + 33});
        step();
        release_req();
        check("b2b_busy_div", 32'(busy_o), 32'd1);
        repeat (6) step();
        drive(3'd0, 32'd9, 32'd9, 5'd9);
        step();
        release_req();
        repeat (25) step();
        @(negedge clk);
        #1;
        check("b2b_drained", 32'(sbq.size()), 32'd0);
        repeat (3) step();
        check("b2b_done_count", 32'(done_cnt - dn0), 32'd2);
        check("b2b_idle", 32'(busy_o), 32'd0);

        // Mixed operands against the reference model
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            f = 3'($urandom_range(0, 7));
            a = pick($urandom_range(0, 5));
            b = pick($urandom_range(0, 5));
            run_op(f, a, b, 5'(i + 1), ref_res(f, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
